// File: rtl/pcm_sram_ctrl_if.sv
// Memory-mapped master port between the PCM memory arbiter and the SRAM back end.
// One outstanding transfer at a time; waitrequest gates acceptance.
interface pcm_sram_ctrl_if;
  logic [19:0] mm_address;
  logic        mm_chipselect;
  logic        mm_write;
  logic [15:0] mm_writedata;
  logic [1:0]  mm_byteenable;
  logic [15:0] mm_readdata;
  logic        mm_readdatavalid;
  logic        mm_waitrequest;

  modport master (
    output mm_address, mm_chipselect, mm_write, mm_writedata, mm_byteenable,
    input  mm_readdata, mm_readdatavalid, mm_waitrequest
  );

  modport slave (
    input  mm_address, mm_chipselect, mm_write, mm_writedata, mm_byteenable,
    output mm_readdata, mm_readdatavalid, mm_waitrequest
  );
endinterface

// File: rtl/pcm_sram_ctrl.sv
// Async SRAM back end: turns one accepted mm transfer into one timed SRAM cycle.
// Optional transfer counters are enabled by defining PCM_SRAM_STATS_EN.
//
// state | meaning
// IDLE  | strobes released, DQ tri-stated, ready to accept
// RD    | CE/OE low for RD_WAIT cycles, data sampled on the last edge
// WR_SU | CE low, DQ driven, WE still high (address/data setup)
// WR    | WE low for WR_WAIT cycles (stays high when byteenable=00)
// WR_HD | WE released while DQ is still driven (data hold)
module pcm_sram_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic                 clk,
  input  logic                 Reset,
  pcm_sram_ctrl_if.slave       mm,
  output logic [19:0]          Mem_ADDR,
  inout  wire  [15:0]          Mem_DQ,
  output logic                 Mem_CE,
  output logic                 Mem_OE,
  output logic                 Mem_WE,
  output logic                 Mem_UB,
  output logic                 Mem_LB,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {IDLE, RD, WR_SU, WR, WR_HD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [15:0]     wdata_q;
  logic [1:0]      be_q;
  logic            dq_oe;
  logic [15:0]     rdata_q;
  logic            rvalid_q;

  assign mm.mm_waitrequest   = (state != IDLE) | ~Reset;
  assign mm.mm_readdata      = rdata_q;
  assign mm.mm_readdatavalid = rvalid_q;
  assign Mem_DQ              = dq_oe ? wdata_q : 16'hzzzz;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      dq_oe    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      Mem_ADDR <= '0;
      Mem_CE   <= 1'b1;
      Mem_OE   <= 1'b1;
      Mem_WE   <= 1'b1;
      Mem_UB   <= 1'b1;
      Mem_LB   <= 1'b1;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mm.mm_chipselect) begin
            Mem_ADDR <= mm.mm_address;
            be_q     <= mm.mm_byteenable;
            Mem_CE   <= 1'b0;
            Mem_UB   <= ~mm.mm_byteenable[1];
            Mem_LB   <= ~mm.mm_byteenable[0];
            if (mm.mm_write) begin
              state   <= WR_SU;
              cnt     <= '0;
              wdata_q <= mm.mm_writedata;
              dq_oe   <= 1'b1;
            end else begin
              state  <= RD;
              cnt    <= CW'(RD_WAIT - 1);
              Mem_OE <= 1'b0;
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            rdata_q  <= Mem_DQ & {{8{be_q[1]}}, {8{be_q[0]}}};
            rvalid_q <= 1'b1;
            state    <= IDLE;
            Mem_CE   <= 1'b1;
            Mem_OE   <= 1'b1;
            Mem_UB   <= 1'b1;
            Mem_LB   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_SU: begin
          state  <= WR;
          cnt    <= CW'(WR_WAIT - 1);
          // with no byte lanes enabled the cycle still runs, but never strobes WE
          Mem_WE <= ~(|be_q);
        end
        WR: begin
          if (cnt == '0) begin
            state  <= WR_HD;
            Mem_WE <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_HD: begin
          state  <= IDLE;
          cnt    <= '0;
          dq_oe  <= 1'b0;
          Mem_CE <= 1'b1;
          Mem_UB <= 1'b1;
          Mem_LB <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PCM_SRAM_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (state == RD && cnt == '0 && rd_cnt_q != 16'hFFFF)
        rd_cnt_q <= rd_cnt_q + 16'd1;
      if (state == WR_HD && wr_cnt_q != 16'hFFFF)
        wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule

// File: doc/pcm_sram_ctrl.md
# pcm_sram_ctrl

Single-port SRAM back end for the PCM memory path. It sits directly downstream of the PCM memory arbiter and accepts that arbiter's one-outstanding-transfer memory-mapped master port. Each accepted transfer becomes one timed asynchronous-SRAM read or write cycle on the board pins (active-low CE/OE/WE/UB/LB, 20-bit address, 16-bit bidirectional data). Wait-state counts are parameters, so the same RTL runs on any SRAM speed grade at the 50 MHz system clock.

## Interface
Parameters:
- RD_WAIT, default 2: cycles OE stays low before read data is sampled (≥1).
- WR_WAIT, default 2: cycles WE is held low (≥1).

Ports:
- clk  in  1  system clock (50 MHz); all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset; clk is the only clock.
- mm_address  in  20  word address.
- mm_chipselect  in  1  request valid.
- mm_write  in  1  1 = write, 0 = read; sampled with chipselect.
- mm_writedata  in  16  write data.
- mm_byteenable  in  2  bit1 = upper byte, bit0 = lower byte.
- mm_readdata  out  16  read data; disabled bytes return 0x00.
- mm_readdatavalid  out  1  one-cycle pulse qualifying mm_readdata.
- mm_waitrequest  out  1  1 = request not accepted this cycle.
- Mem_ADDR  out  20  SRAM address.
- Mem_DQ  inout  16  SRAM data bus.
- Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB  out  1 each  SRAM strobes, active-low.
- rd_count, wr_count  out  16 each  completed-transfer counters (see Configuration).

## Operation
- FSM states: IDLE, RD, WR_SU, WR, WR_HD.
- **Accept rule:** a transfer is accepted on an edge where the FSM is in IDLE and mm_chipselect=1.
  - mm_waitrequest = (state≠IDLE) | ~Reset.
  - On accept, latch address, data, byteenable and direction.
  - After accept, the master may drop or change its inputs.
- **IDLE:**
  - CE=OE=WE=UB=LB=1; Mem_DQ is tri-stated.
  - Mem_ADDR holds the last address.
  - On accept, go to RD (read) or WR_SU (write).
- **RD, RD_WAIT cycles:**
  - CE=0, OE=0, UB=~be[1], LB=~be[0].
  - On the edge ending the last RD cycle, register Mem_DQ masked by byteenable into mm_readdata, then go to IDLE.
  - mm_readdatavalid=1 for exactly the following cycle.
  - mm_readdata holds its value until the next read completes.
- **WR_SU, 1 cycle:** CE=0, WE=1, UB/LB from be, Mem_DQ driven with the data.
- **WR, WR_WAIT cycles:** as WR_SU with WE=0.
- **WR_HD, 1 cycle:** WE=1 while Mem_DQ is still driven, then go to IDLE.
- **Drive rule:** Mem_DQ is driven only in WR_SU/WR/WR_HD. OE is never low in those states.
- **byteenable=00:**
  - The transfer takes the normal cycle count.
  - UB=LB=1 and WE stays 1 throughout.
  - A read returns 0x0000 with a normal readdatavalid.
- **Wait counter:** one counter, reloaded on every state entry; width ≥ clog2(max(RD_WAIT, WR_WAIT)+1).

## Timing
- All SRAM pins and mm_readdata/mm_readdatavalid are registered.
- mm_waitrequest is combinational from state and Reset only.
- **Read:** accepted at edge k; OE low during cycles k+1..k+RD_WAIT; readdatavalid high in cycle k+RD_WAIT+1.
  - The FSM is back in IDLE in that cycle and may accept the next transfer.
  - Sustained throughput is one read per RD_WAIT+1 cycles.
- **Write:** accepted at edge k; next accept possible at edge k+WR_WAIT+3.
- **Read→write:** OE goes high in the IDLE cycle before WR_SU drives DQ, so no bus contention.
- **Reset (async, Reset=0):**
  - Strobes=1, Mem_ADDR=0, Mem_DQ=Z, mm_readdata=0, mm_readdatavalid=0, counters=0, state=IDLE, mm_waitrequest=1.
  - Reset mid-transfer aborts it: no readdatavalid, WE released immediately.
  - Operation resumes on the first edge after Reset rises.

## Configuration
- PCM_SRAM_STATS_EN defined:
  - rd_count increments in the cycle readdatavalid is asserted.
  - wr_count increments on exit from WR_HD.
  - Both are 16-bit, saturate at 0xFFFF and clear only on reset.
- Undefined: both ports are tied to 0 and no counter logic is synthesized.

## Test plan
- Reset with no requests, then release → all strobes 1, Mem_DQ=Z, waitrequest 1→0, readdata 0.
- Write 0xBEEF to 0x00123, be=11, default params → WE low exactly 2 cycles; DQ=0xBEEF from WR_SU through WR_HD; next accept 5 edges later.
- Read 0x00123 with SRAM model returning 0xBEEF, be=01 → OE low 2 cycles, LB=0, UB=1; readdata=0x00EF with readdatavalid one cycle, 3 cycles after accept.
- Back-to-back read, write, read with chipselect held → DQ never driven while OE=0; second read returns the newly written data; STATS build shows rd_count=2, wr_count=1.
- Reset pulsed during the second RD cycle → no readdatavalid, strobes high asynchronously; a fresh read afterwards completes normally.
- RD_WAIT=1, WR_WAIT=3, be=00 write then be=00 read → WE never low; write takes 5 cycles; read returns 0x0000 after 2 cycles.
